// File: rtl/mem_access_initiator.sv
// mem_access_initiator
//   Initiator-side memory sequencer between the multi-cycle datapath and an
//   asynchronous word memory (combinational read with fixed latency, write on
//   the rising clock edge). Accepts one word read or write at a time with a
//   ready/valid request. It holds mem_read for READ_WAIT cycles, then samples
//   the read word. Completion is reported with a single-cycle rsp_valid pulse.
//
// Parameters
//   ADDR_W     request / memory address width
//   DATA_W     data word width
//   READ_WAIT  cycles mem_read is held before read data is sampled (>= 1)
//   CNT_W      wait-counter width, 2**CNT_W must exceed READ_WAIT
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous active-low reset (0 = in reset)
//   req_valid       request present
//   req_ready       block can accept a request (IDLE and out of reset)
//   req_write       1 = write, 0 = read
//   req_addr        byte address
//   req_wdata       write data
//   rsp_valid       one-cycle completion pulse
//   rsp_rdata       last captured read word
//   rsp_err         qualifies rsp_valid: misaligned request, memory untouched
//   mem_addr        word-aligned memory address
//   mem_read        memory read enable
//   mem_write       memory write enable, sampled by memory at posedge
//   mem_write_data  memory write data
//   mem_read_data   memory read data (undefined while mem_read = 0)
//   busy            high in any state other than IDLE
module mem_access_initiator #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int READ_WAIT = 3,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              mem_read_d;
  logic              mem_write_d;
  logic [DATA_W-1:0] mem_write_data_d;
  logic              rsp_valid_d;
  logic              rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              handshake;

  // Both are decoded straight from the state register; the reset term makes
  // req_ready drop the instant reset asserts, not at the next edge.
  assign req_ready = (state == S_IDLE) && reset;
  assign busy      = (state != S_IDLE);
  assign handshake = req_valid && req_ready;

  // Next-state and next-output logic. Every output is computed here one cycle
  // early and registered below, so the memory sees glitch-free strobes.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    state_d          = state;
    cnt_d            = cnt;
    mem_addr_d       = mem_addr;
    mem_read_d       = 1'b0;
    mem_write_d      = 1'b0;
    mem_write_data_d = mem_write_data;
    rsp_valid_d      = 1'b0;
    rsp_err_d        = 1'b0;
    rsp_rdata_d      = rsp_rdata;

    unique case (state)
      S_IDLE: begin
        if (handshake) begin
          // Address is driven word-aligned and then held until the next
          // handshake, even through IDLE.
          mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
          if (req_addr[1:0] != 2'b00) begin
            // Misaligned: answer at once with an error, never touch memory.
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_write) begin
            state_d          = S_WR;
            mem_write_d      = 1'b1;
            mem_write_data_d = req_wdata;
          end else begin
            state_d    = S_RD;
            mem_read_d = 1'b1;
            cnt_d      = CNT_W'(READ_WAIT - 1);
          end
        end
      end

      S_RD: begin
        if (cnt == '0) begin
          // Read latency has elapsed: this edge samples the memory word.
          rsp_rdata_d = mem_read_data;
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          mem_read_d = 1'b1;
          cnt_d      = cnt - 1'b1;
        end
      end

      // The memory commits the write on the edge leaving this state.
      S_WR: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the captured read word is a single architectural register, not a
      // memory array, so it is reset to a known 0 along with the control flops.
      state          <= S_IDLE;
      cnt            <= '0;
      mem_addr       <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_write_data <= '0;
      rsp_valid      <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_rdata      <= '0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      mem_addr       <= mem_addr_d;
      mem_read       <= mem_read_d;
      mem_write      <= mem_write_d;
      mem_write_data <= mem_write_data_d;
      rsp_valid      <= rsp_valid_d;
      rsp_err        <= rsp_err_d;
      rsp_rdata      <= rsp_rdata_d;
    end
  end

endmodule
